hidden_layer_mac: RTL and testbench
===================================

# hidden_layer_mac

Hidden-layer matrix multiplier of the two-layer network datapath. Computes RES = A × B with three fixed shapes: A is the 64×8 input matrix (bias column included), B is the 8×2 hidden weight matrix, and RES is the 64×2 pre-activation matrix. It sits directly upstream of the sigmoid stage, which consumes RES. Operation is a sequential multiply-accumulate over memories with 1-cycle registered read latency, bracketed by a Start/End handshake.

## Interface
- width, 8, data width of A, B and RES entries (unsigned, scale 1/256)
- A_depth_bits, 9, A address width (64×8 = 512 entries)
- B_depth_bits, 4, B address width (8×2 = 16 entries)
- RES_depth_bits, 7, RES address width (64×2 = 128 entries)
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- Start_Hidden  in  1  start request; sampled only in IDLE
- End_Hidden  out  1  one-cycle completion pulse
- A_read_en  out  1  A memory read enable
- A_read_address  out  A_depth_bits  row-major: row*8 + k
- A_read_data_out  in  width  A data, valid 1 cycle after address
- B_read_en  out  1  B memory read enable
- B_read_address  out  B_depth_bits  row-major: k*2 + col
- B_read_data_out  in  width  B data, valid 1 cycle after address
- RES_write_en  out  1  RES write strobe, one cycle per element
- RES_write_address  out  RES_depth_bits  row*2 + col
- RES_write_data_in  out  width  result element

## Operation
- Counters: row 0..63, col 0..1, k 0..7; accumulator acc ≥ 19 bits, unsigned.
- States: IDLE, MAC, TAIL, WRITE, DONE.
- IDLE: if Start_Hidden=1, clear row/col/k/acc and go to MAC. Otherwise stay.
- MAC: read enables high; addresses are driven from the current row, col and k. If k>0, acc += A_data × B_data, where the operands are the data returned for k−1. k increments. When k=7, go to TAIL.
- TAIL: acc + product(k=7) is the final sum S. Register RES_write_en=1, RES_write_address=row*2+col, RES_write_data_in=f(S). Go to WRITE.
- WRITE: the write strobe is visible this cycle. Clear acc and k, then advance col, then row (col wraps 1→0 and increments row). After the element (63,1), go to DONE. Otherwise go to MAC.
- DONE: End_Hidden=1 for this cycle only. Go to IDLE.
- f(S) = S >> 8, then handled per Configuration.
- Element order: (0,0), (0,1), (1,0), … (63,1).
- Outside MAC: read enables are 0 and read addresses are 0.
- Outside WRITE: RES_write_en is 0.
- Start_Hidden is ignored outside IDLE. The controller drops Start_Hidden on End_Hidden. The DONE→IDLE cycle provides the slack for this. If Start_Hidden is still high in IDLE, a new run starts.

## Timing
- Reset: state IDLE. All outputs 0, including End_Hidden, enables, addresses and RES data. Counters and acc are 0.
- Reset mid-run: abort next cycle. No further RES writes. End_Hidden is not asserted.
- Start accepted at edge 0. MAC occupies cycles 1–8, TAIL cycle 9, WRITE cycle 10.
- Element e is written in cycle 10 + 10e. The last write is in cycle 1280.
- End_Hidden is high in cycle 1281. IDLE resumes in cycle 1282.
- Total latency from Start to End is 1281 cycles, with exactly 128 RES writes.
- Memory read data is sampled exactly one cycle after its address. No extra wait states.

## Configuration
- HIDDEN_SAT_EN defined: RES_write_data_in = min(S >> 8, 255), saturating.
- HIDDEN_SAT_EN undefined: RES_write_data_in = (S >> 8)[7:0], plain truncation with wrap.
- All other behaviour and timing are identical in both builds.

## Test plan
- A all 16, B all 16, single Start → 128 writes, each RES=8 (8×256>>8). End_Hidden pulses in cycle 1281 only.
- A[r][k]=r+k, B col0 = k=0 entry 255 with others 0, col1 all 0 → RES[r][0] = ((r×255)>>8), RES[r][1]=0. Check addresses are ordered 0..127 and each write is exactly 10 cycles apart.
- A all 255, B all 255 (S=520200) → RES=255 with HIDDEN_SAT_EN, RES=240 without.
- Assert rst at cycle 500 → outputs 0 next cycle. No further writes, no End_Hidden. A restart gives a full correct run.
- Hold Start_Hidden high through End_Hidden → second run begins in cycle 1282 with identical results.
- Toggle Start_Hidden mid-run → no effect on sequence or result.

Source files
------------

// File: rtl/hidden_layer_mac_if.sv
// Bus bundle for hidden_layer_mac: Start/End handshake, A/B read ports and RES write port.
// master = the multiplier (drives memory requests), slave = memories and controller side.
interface hidden_layer_mac_if #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 4,
  parameter int RES_depth_bits = 7
);
  logic                      Start_Hidden;
  logic                      End_Hidden;

  logic                      A_read_en;
  logic [A_depth_bits-1:0]   A_read_address;
  logic [width-1:0]          A_read_data_out;

  logic                      B_read_en;
  logic [B_depth_bits-1:0]   B_read_address;
  logic [width-1:0]          B_read_data_out;

  logic                      RES_write_en;
  logic [RES_depth_bits-1:0] RES_write_address;
  logic [width-1:0]          RES_write_data_in;

  modport master (
    input  Start_Hidden,
    input  A_read_data_out,
    input  B_read_data_out,
    output End_Hidden,
    output A_read_en,
    output A_read_address,
    output B_read_en,
    output B_read_address,
    output RES_write_en,
    output RES_write_address,
    output RES_write_data_in
  );

  modport slave (
    output Start_Hidden,
    output A_read_data_out,
    output B_read_data_out,
    input  End_Hidden,
    input  A_read_en,
    input  A_read_address,
    input  B_read_en,
    input  B_read_address,
    input  RES_write_en,
    input  RES_write_address,
    input  RES_write_data_in
  );
endinterface

// File: rtl/hidden_layer_mac.sv
// Hidden-layer multiplier RES(64x2) = A(64x8) x B(8x2), sequential MAC over 1-cycle-latency memories.
// Optional macro HIDDEN_SAT_EN: saturate RES to 255 instead of truncating (S >> 8).
module hidden_layer_mac #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 4,
  parameter int RES_depth_bits = 7
) (
  input  logic               clk,
  input  logic               rst,
  hidden_layer_mac_if.master bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MAC   = 3'd1;
  localparam logic [2:0] TAIL  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Eight products of two width-bit operands need 3 guard bits.
  localparam int ACC_W = 2 * width + 3;
  localparam int SH_W  = ACC_W - width;

  logic [2:0]         state;
  logic [5:0]         row;
  logic               col;
  logic [2:0]         k;
  logic [ACC_W-1:0]   acc;

  logic [2*width-1:0] product;
  logic [ACC_W-1:0]   sum;
  logic [width-1:0]   res_value;

  logic                      res_en;
  logic [RES_depth_bits-1:0] res_addr;
  logic [width-1:0]          res_data;

  logic in_mac;

  assign product = bus.A_read_data_out * bus.B_read_data_out;
  assign sum     = acc + ACC_W'(product);

`ifdef HIDDEN_SAT_EN
  logic [SH_W-1:0] shifted;
  assign shifted   = SH_W'(sum >> width);
  assign res_value = (shifted > SH_W'((2 ** width) - 1)) ? '1 : width'(shifted);
`else
  assign res_value = width'(sum >> width);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      col      <= 1'b0;
      k        <= '0;
      acc      <= '0;
      res_en   <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
    end else begin
      res_en <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start_Hidden) begin
            row   <= '0;
            col   <= 1'b0;
            k     <= '0;
            acc   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          // Data on the read ports belongs to k-1; nothing is valid yet at k=0.
          if (k != 3'd0)
            acc <= sum;
          k <= k + 3'd1;
          if (k == 3'd7)
            state <= TAIL;
        end
        TAIL: begin
          res_en   <= 1'b1;
          res_addr <= RES_depth_bits'({row, col});
          res_data <= res_value;
          state    <= WRITE;
        end
        WRITE: begin
          acc <= '0;
          k   <= '0;
          col <= ~col;
          if (col)
            row <= row + 6'd1;
          if (col && (row == 6'd63))
            state <= DONE;
          else
            state <= MAC;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_mac = (state == MAC);

  assign bus.A_read_en      = in_mac;
  assign bus.A_read_address = in_mac ? A_depth_bits'({row, k}) : '0;
  assign bus.B_read_en      = in_mac;
  assign bus.B_read_address = in_mac ? B_depth_bits'({k, col}) : '0;

  assign bus.RES_write_en      = res_en;
  assign bus.RES_write_address = res_addr;
  assign bus.RES_write_data_in = res_data;

  assign bus.End_Hidden = (state == DONE);

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench for hidden_layer_mac: memory models, write/End monitor and assertion-based checks.
module tb_hidden_layer_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hidden_layer_mac_if bus ();

  hidden_layer_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] A_mem [512];
  logic [7:0] B_mem [16];
  logic [7:0] a_q = '0;
  logic [7:0] b_q = '0;
  logic [7:0] exp_res [128];

  always @(posedge clk) begin
    if (bus.A_read_en) a_q <= A_mem[bus.A_read_address];
    if (bus.B_read_en) b_q <= B_mem[bus.B_read_address];
  end
  assign bus.A_read_data_out = a_q;
  assign bus.B_read_data_out = b_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every RES write and End pulse with its cycle stamp.
  int         wr_n = 0;
  int         end_n = 0;
  int         proto_err = 0;
  logic [6:0] wr_addr [1024];
  logic [7:0] wr_data [1024];
  int         wr_cyc  [1024];
  int         end_cyc [16];

  always @(negedge clk) begin
    if (bus.RES_write_en) begin
      if (wr_n < 1024) begin
        wr_addr[wr_n] = bus.RES_write_address;
        wr_data[wr_n] = bus.RES_write_data_in;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (bus.End_Hidden) begin
      if (end_n < 16) end_cyc[end_n] = cyc;
      end_n = end_n + 1;
    end
    if (!bus.A_read_en && bus.A_read_address != '0) proto_err = proto_err + 1;
    if (!bus.B_read_en && bus.B_read_address != '0) proto_err = proto_err + 1;
    if (bus.A_read_en != bus.B_read_en) proto_err = proto_err + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic build_expected();
    for (int unsigned r = 0; r < 64; r++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        int unsigned s = 0;
        int unsigned q;
        for (int unsigned kk = 0; kk < 8; kk++)
          s += A_mem[r*8 + kk] * B_mem[kk*2 + c];
        q = s >> 8;
`ifdef HIDDEN_SAT_EN
        exp_res[r*2 + c] = (q > 255) ? 8'd255 : q[7:0];
`else
        exp_res[r*2 + c] = q[7:0];
`endif
      end
    end
  endtask

  // Raises Start for one cycle; c0 is the cyc value of the accepting cycle (edge 0).
  task automatic start_run(output int c0);
    @(posedge clk); #1;
    bus.Start_Hidden = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    bus.Start_Hidden = 1'b0;
  endtask

  task automatic check_run(input string tag, input int c0, input int base, input int n);
    for (int e = 0; e < n; e++) begin
      check($sformatf("%s_addr%0d", tag, e), 32'(wr_addr[base+e]), 32'(e));
      check($sformatf("%s_data%0d", tag, e), 32'(wr_data[base+e]), 32'(exp_res[e]));
      check($sformatf("%s_cyc%0d", tag, e), 32'(wr_cyc[base+e]), 32'(c0 + 10 + 10*e));
    end
  endtask

  task automatic fill_distinct();
    for (int i = 0; i < 512; i++) A_mem[i] = 8'(((i >> 3) * 3 + (i & 7) * 5) & 255);
    for (int j = 0; j < 16; j++)  B_mem[j] = 8'((j >> 1) * 7 + (j & 1) * 11 + 1);
  endtask

  initial begin
    int c0;
    int wb;
    int eb;

    bus.Start_Hidden = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_end",      32'(bus.End_Hidden), 0);
    check("rst_a_en",     32'(bus.A_read_en), 0);
    check("rst_a_addr",   32'(bus.A_read_address), 0);
    check("rst_b_en",     32'(bus.B_read_en), 0);
    check("rst_b_addr",   32'(bus.B_read_address), 0);
    check("rst_res_en",   32'(bus.RES_write_en), 0);
    check("rst_res_addr", 32'(bus.RES_write_address), 0);
    check("rst_res_data", 32'(bus.RES_write_data_in), 0);

    // Run 1: all 16 -> every element is 8.
    for (int i = 0; i < 512; i++) A_mem[i] = 8'd16;
    for (int j = 0; j < 16; j++)  B_mem[j] = 8'd16;
    build_expected();
    wb = wr_n; eb = end_n;
    start_run(c0);
    repeat (1300) @(posedge clk);
    @(negedge clk);
    check("r1_count", 32'(wr_n - wb), 128);
    check("r1_end_count", 32'(end_n - eb), 1);
    check("r1_end_cyc", 32'(end_cyc[eb]), 32'(c0 + 1281));
    check("r1_first", 32'(wr_data[wb]), 8);
    check("r1_last", 32'(wr_data[wb+127]), 8);
    check_run("r1", c0, wb, 128);

    // Run 2: A[r][k]=r+k, B only k=0/col0 = 255.
    for (int i = 0; i < 512; i++) A_mem[i] = 8'((i >> 3) + (i & 7));
    for (int j = 0; j < 16; j++)  B_mem[j] = (j == 0) ? 8'd255 : 8'd0;
    build_expected();
    wb = wr_n; eb = end_n;
    start_run(c0);
    repeat (1300) @(posedge clk);
    @(negedge clk);
    check("r2_count", 32'(wr_n - wb), 128);
    check("r2_r2c0", 32'(wr_data[wb+4]), 1);
    check("r2_r63c0", 32'(wr_data[wb+126]), 62);
    check("r2_r63c1", 32'(wr_data[wb+127]), 0);
    check_run("r2", c0, wb, 128);

    // Run 3: all 255, S = 520200.
    for (int i = 0; i < 512; i++) A_mem[i] = 8'd255;
    for (int j = 0; j < 16; j++)  B_mem[j] = 8'd255;
    build_expected();
    wb = wr_n; eb = end_n;
    start_run(c0);
    repeat (1300) @(posedge clk);
    @(negedge clk);
    check("r3_count", 32'(wr_n - wb), 128);
`ifdef HIDDEN_SAT_EN
    check("r3_sat_first", 32'(wr_data[wb]), 255);
    check("r3_sat_last", 32'(wr_data[wb+127]), 255);
`else
    check("r3_wrap_first", 32'(wr_data[wb]), 240);
    check("r3_wrap_last", 32'(wr_data[wb+127]), 240);
`endif

    // Run 4: reset asserted in cycle 500 aborts; elements 0..49 already written.
    fill_distinct();
    build_expected();
    wb = wr_n; eb = end_n;
    start_run(c0);
    repeat (499) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("r4_rst_cyc", 32'(cyc), 32'(c0 + 501));
    check("r4_rst_a_en", 32'(bus.A_read_en), 0);
    check("r4_rst_a_addr", 32'(bus.A_read_address), 0);
    check("r4_rst_b_addr", 32'(bus.B_read_address), 0);
    check("r4_rst_res_en", 32'(bus.RES_write_en), 0);
    check("r4_rst_res_addr", 32'(bus.RES_write_address), 0);
    check("r4_rst_res_data", 32'(bus.RES_write_data_in), 0);
    check("r4_rst_end", 32'(bus.End_Hidden), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (1400) @(posedge clk);
    @(negedge clk);
    check("r4_count", 32'(wr_n - wb), 50);
    check("r4_end_count", 32'(end_n - eb), 0);
    check_run("r4", c0, wb, 50);

    // Restart after abort: full correct run.
    wb = wr_n; eb = end_n;
    start_run(c0);
    repeat (1300) @(posedge clk);
    @(negedge clk);
    check("r5_count", 32'(wr_n - wb), 128);
    check("r5_end_count", 32'(end_n - eb), 1);
    check_run("r5", c0, wb, 128);

    // Start held through End: back-to-back second run from cycle 1282.
    wb = wr_n; eb = end_n;
    @(posedge clk); #1;
    bus.Start_Hidden = 1'b1;
    c0 = cyc;
    repeat (1283) @(posedge clk); #1;
    bus.Start_Hidden = 1'b0;
    repeat (1300) @(posedge clk);
    @(negedge clk);
    check("r6_count", 32'(wr_n - wb), 256);
    check("r6_end_count", 32'(end_n - eb), 2);
    check("r6_end0_cyc", 32'(end_cyc[eb]), 32'(c0 + 1281));
    check("r6_end1_cyc", 32'(end_cyc[eb+1]), 32'(c0 + 2563));
    check_run("r6a", c0, wb, 128);
    check_run("r6b", c0 + 1282, wb + 128, 128);

    // Start toggled mid-run: no effect.
    wb = wr_n; eb = end_n;
    start_run(c0);
    for (int t = 0; t < 32; t++) begin
      repeat (37) @(posedge clk); #1;
      bus.Start_Hidden = ~bus.Start_Hidden;
    end
    bus.Start_Hidden = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("r7_count", 32'(wr_n - wb), 128);
    check("r7_end_count", 32'(end_n - eb), 1);
    check("r7_end_cyc", 32'(end_cyc[eb]), 32'(c0 + 1281));
    check_run("r7", c0, wb, 128);

    check("read_port_idle_zero", 32'(proto_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
